// File: rtl/lsu_sram_pipe.sv
// MEM-stage load/store unit driving an SRAM-like req/addr_ok/data_ok bus with in-order load returns.
// Optional feature macro: LSU_UNALIGNED_EXC_EN (misaligned access raises exc_adel/exc_ades instead of aligning).
module lsu_sram_pipe #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int OT_DEPTH = 2,
    parameter int TAG_W    = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  ls_valid,
    output logic                  ls_ready,
    input  logic [3:0]            ls_sel,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [31:0]           ls_wdata,
    input  logic [TAG_W-1:0]      ls_tag,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_data,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic                  exc_adel,
    output logic                  exc_ades,
    output logic [ADDR_W-1:0]     exc_badvaddr,
    output logic                  busy,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_W-1:0]     data_addr,
    output logic [DATA_W/8-1:0]   data_wstrb,
    output logic [DATA_W-1:0]     data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [DATA_W-1:0]     data_rdata
);
    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int PTR_W = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OT_DEPTH + 1);
    localparam int ENT_W = 1 + 4 + OFF_W + TAG_W;

    localparam logic [3:0] LS_SEL_LB  = 4'd1;
    localparam logic [3:0] LS_SEL_LBU = 4'd2;
    localparam logic [3:0] LS_SEL_LH  = 4'd3;
    localparam logic [3:0] LS_SEL_LHU = 4'd4;
    localparam logic [3:0] LS_SEL_LW  = 4'd5;
    localparam logic [3:0] LS_SEL_SB  = 4'd6;
    localparam logic [3:0] LS_SEL_SH  = 4'd7;
    localparam logic [3:0] LS_SEL_SW  = 4'd8;

    typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

    function automatic logic sel_known(input logic [3:0] sel);
        case (sel)
            LS_SEL_LB, LS_SEL_LBU, LS_SEL_LH, LS_SEL_LHU,
            LS_SEL_LW, LS_SEL_SB, LS_SEL_SH, LS_SEL_SW: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    function automatic logic sel_store(input logic [3:0] sel);
        case (sel)
            LS_SEL_SB, LS_SEL_SH, LS_SEL_SW: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] sel_size(input logic [3:0] sel);
        case (sel)
            LS_SEL_LB, LS_SEL_LBU, LS_SEL_SB: return 2'd0;
            LS_SEL_LH, LS_SEL_LHU, LS_SEL_SH: return 2'd1;
            LS_SEL_LW, LS_SEL_SW:             return 2'd2;
            default:                          return 2'd0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [3:0] sel, input logic [1:0] lo);
        return ((sel_size(sel) == 2'd1) && lo[0]) || ((sel_size(sel) == 2'd2) && (lo != 2'b00));
    endfunction

    state_t               state_r;
    logic [3:0]           sel_r;
    logic [ADDR_W-1:0]    addr_r;
    logic [TAG_W-1:0]     tag_r;
    logic [LANES-1:0]     wstrb_r;
    logic [DATA_W-1:0]    wdata_r;
    logic [ENT_W-1:0]     fifo_r [OT_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]     count_r;

    logic                 full_s, pop_s, push_s, accept_s, take_s;
    logic [ADDR_W-1:0]    addr_al_s;
    logic [OFF_W-1:0]     off_s;
    logic [LANES-1:0]     wstrb_s;
    logic [DATA_W-1:0]    wdata_s;
    logic [ENT_W-1:0]     head_s;
    logic [DATA_W-1:0]    shifted_s;

    assign full_s    = (count_r == CNT_W'(OT_DEPTH));
    assign pop_s     = data_data_ok && (count_r != '0);
    assign data_req  = (state_r == S_REQ) && (!full_s || pop_s);
    assign push_s    = data_req && data_addr_ok;
    assign accept_s  = ls_valid && ls_ready;
    assign busy      = (state_r == S_REQ) || (count_r != '0);
    assign data_addr = addr_r;
    assign data_wr   = sel_store(sel_r);
    assign data_size = sel_size(sel_r);
    assign data_wstrb = wstrb_r;
    assign data_wdata = wdata_r;

    // Handshake toward EX: a new request may ride on the address-phase acceptance of the current one.
    always_comb begin
        ls_ready = 1'b0;
        if (state_r == S_IDLE) begin
            ls_ready = !full_s;
        end else begin
            ls_ready = push_s;
        end
    end

`ifdef LSU_UNALIGNED_EXC_EN
    logic mis_s;
    assign mis_s    = misaligned(ls_sel, ls_addr[1:0]);
    assign exc_adel = accept_s && mis_s && !sel_store(ls_sel);
    assign exc_ades = accept_s && mis_s && sel_store(ls_sel);
    assign take_s   = accept_s && sel_known(ls_sel) && !mis_s;

    // Faulting address is held until the next exception.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exc_badvaddr <= '0;
        end else if (exc_adel || exc_ades) begin
            exc_badvaddr <= ls_addr;
        end
    end
`else
    assign exc_adel     = 1'b0;
    assign exc_ades     = 1'b0;
    assign exc_badvaddr = '0;
    assign take_s       = accept_s && sel_known(ls_sel);
`endif

    // Align by clearing low address bits; a no-op for accesses that are already aligned.
    always_comb begin
        addr_al_s = ls_addr;
        if (sel_size(ls_sel) == 2'd1) begin
            addr_al_s[0] = 1'b0;
        end else if (sel_size(ls_sel) == 2'd2) begin
            addr_al_s[1:0] = 2'b00;
        end else begin
            addr_al_s = ls_addr;
        end
    end

    assign off_s = addr_al_s[OFF_W-1:0];

    // Store data is replicated across every lane; the strobe picks the lanes actually written.
    always_comb begin
        wstrb_s = '0;
        wdata_s = '0;
        if (sel_store(ls_sel)) begin
            case (sel_size(ls_sel))
                2'd0: begin
                    wstrb_s = LANES'(4'h1) << off_s;
                    wdata_s = {LANES{ls_wdata[7:0]}};
                end
                2'd1: begin
                    wstrb_s = LANES'(4'h3) << off_s;
                    wdata_s = {(LANES/2){ls_wdata[15:0]}};
                end
                default: begin
                    wstrb_s = LANES'(4'hF) << off_s;
                    wdata_s = {(LANES/4){ls_wdata}};
                end
            endcase
        end else begin
            wstrb_s = '0;
            wdata_s = '0;
        end
    end

    // Request FSM: IDLE waits for work, REQ holds the bus request until addr_ok.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: if (take_s) state_r <= S_REQ;
                S_REQ:  if (push_s && !take_s) state_r <= S_IDLE;
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // Request registers feeding the bus.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_r   <= 4'd0;
            addr_r  <= '0;
            tag_r   <= '0;
            wstrb_r <= '0;
            wdata_r <= '0;
        end else if (take_s) begin
            sel_r   <= ls_sel;
            addr_r  <= addr_al_s;
            tag_r   <= ls_tag;
            wstrb_r <= wstrb_s;
            wdata_r <= wdata_s;
        end
    end

    // Outstanding-transaction metadata FIFO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < OT_DEPTH; i++) fifo_r[i] <= '0;
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= {!sel_store(sel_r), sel_r, addr_r[OFF_W-1:0], tag_r};
                wr_ptr_r <= (wr_ptr_r == PTR_W'(OT_DEPTH - 1)) ? '0 : wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(OT_DEPTH - 1)) ? '0 : rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_s    = fifo_r[rd_ptr_r];
    assign rsp_valid = pop_s && head_s[ENT_W-1];
    assign shifted_s = data_rdata >> {head_s[TAG_W +: OFF_W], 3'b000};

    // Load result extraction and extension, shown only while a load pops.
    always_comb begin
        rsp_data = 32'h0;
        rsp_tag  = '0;
        if (rsp_valid) begin
            rsp_tag = head_s[TAG_W-1:0];
            case (head_s[ENT_W-2 -: 4])
                LS_SEL_LB:  rsp_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
                LS_SEL_LBU: rsp_data = {24'h0, shifted_s[7:0]};
                LS_SEL_LH:  rsp_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
                LS_SEL_LHU: rsp_data = {16'h0, shifted_s[15:0]};
                default:    rsp_data = shifted_s[31:0];
            endcase
        end else begin
            rsp_data = 32'h0;
            rsp_tag  = '0;
        end
    end
endmodule

// File: tb/tb_lsu_sram_pipe.sv
// Self-checking bench for lsu_sram_pipe: directed scenarios plus random traffic against a
// queue-based transaction model of the load/store unit.
module tb_lsu_sram_pipe;
    localparam int OT = 2;
`ifdef LSU_UNALIGNED_EXC_EN
    localparam bit EXC = 1'b1;
`else
    localparam bit EXC = 1'b0;
`endif
    localparam logic [3:0] LB = 4'd1, LBU = 4'd2, LH = 4'd3, LHU = 4'd4, LW = 4'd5;
    localparam logic [3:0] SB = 4'd6, SH = 4'd7, SW = 4'd8;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        ls_valid = 1'b0, ls_ready;
    logic [3:0]  ls_sel = 4'd0;
    logic [31:0] ls_addr = 32'h0, ls_wdata = 32'h0;
    logic [4:0]  ls_tag = 5'd0;
    logic        rsp_valid, exc_adel, exc_ades, busy, data_req, data_wr;
    logic [31:0] rsp_data, exc_badvaddr, data_addr, data_wdata;
    logic [4:0]  rsp_tag;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'h0;

    lsu_sram_pipe #(.ADDR_W(32), .DATA_W(32), .OT_DEPTH(OT), .TAG_W(5)) dut (
        .clk(clk), .resetn(resetn), .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_sel(ls_sel),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_tag(ls_tag), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .exc_adel(exc_adel), .exc_ades(exc_ades),
        .exc_badvaddr(exc_badvaddr), .busy(busy), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  tag;
    } req_t;

    req_t        req_q[$];
    req_t        ot_q[$];
    logic [31:0] exp_bad = 32'h0;
    int          passed = 0, total = 0;

    function automatic int nbytes(input logic [3:0] sel);
        if (sel == LB || sel == LBU || sel == SB) return 1;
        if (sel == LH || sel == LHU || sel == SH) return 2;
        if (sel == LW || sel == SW) return 4;
        return 0;
    endfunction

    function automatic bit is_st(input logic [3:0] sel);
        return (sel == SB) || (sel == SH) || (sel == SW);
    endfunction

    function automatic bit is_mis(input logic [3:0] sel, input logic [31:0] addr);
        return (nbytes(sel) > 1) && ((addr % nbytes(sel)) != 0);
    endfunction

    function automatic logic [31:0] exp_strb(input logic [3:0] sel, input logic [31:0] addr);
        if (!is_st(sel)) return 32'h0;
        return ((32'd1 << nbytes(sel)) - 32'd1) << (addr % 4);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [3:0] sel, input logic [31:0] wd);
        if (nbytes(sel) == 1) return (wd % 256) * 32'h01010101;
        if (nbytes(sel) == 2) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_rsp(input logic [3:0] sel, input logic [31:0] addr,
                                            input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * (addr % 4));
        if (sel == LB)  return ((v % 256) >= 128) ? (v % 256) - 32'd256 : v % 256;
        if (sel == LBU) return v % 256;
        if (sel == LH)  return ((v % 65536) >= 32768) ? (v % 65536) - 32'd65536 : v % 65536;
        if (sel == LHU) return v % 65536;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_req(input bit v, input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] tag);
        ls_valid = v; ls_sel = sel; ls_addr = addr; ls_wdata = wd; ls_tag = tag;
    endtask

    // One clock: compare every visible output against the model, then advance the model.
    task automatic tick();
        req_t r;
        bit   pp, ereq, psh, erdy, acc, mis;
        #1;
        pp   = data_data_ok && (ot_q.size() != 0);
        ereq = (req_q.size() != 0) && ((ot_q.size() < OT) || pp);
        psh  = ereq && data_addr_ok;
        erdy = (req_q.size() == 0) ? (ot_q.size() < OT) : psh;
        acc  = ls_valid && erdy;
        mis  = is_mis(ls_sel, ls_addr);
        chk("ls_ready", {31'h0, ls_ready}, {31'h0, erdy});
        chk("data_req", {31'h0, data_req}, {31'h0, ereq});
        chk("busy", {31'h0, busy}, {31'h0, (req_q.size() != 0) || (ot_q.size() != 0)});
        if (ereq) begin
            r = req_q[0];
            chk("data_addr", data_addr, r.addr);
            chk("data_wr", {31'h0, data_wr}, {31'h0, is_st(r.sel)});
            chk("data_size", {30'h0, data_size}, (nbytes(r.sel) == 1) ? 32'd0 :
                                                 (nbytes(r.sel) == 2) ? 32'd1 : 32'd2);
            chk("data_wstrb", {28'h0, data_wstrb}, exp_strb(r.sel, r.addr));
            if (is_st(r.sel)) chk("data_wdata", data_wdata, exp_wdata(r.sel, r.wdata));
        end
        if (pp && !is_st(ot_q[0].sel)) begin
            chk("rsp_valid", {31'h0, rsp_valid}, 32'd1);
            chk("rsp_data", rsp_data, exp_rsp(ot_q[0].sel, ot_q[0].addr, data_rdata));
            chk("rsp_tag", {27'h0, rsp_tag}, {27'h0, ot_q[0].tag});
        end else begin
            chk("rsp_valid", {31'h0, rsp_valid}, 32'd0);
        end
        chk("exc_adel", {31'h0, exc_adel}, {31'h0, EXC && acc && mis && !is_st(ls_sel)});
        chk("exc_ades", {31'h0, exc_ades}, {31'h0, EXC && acc && mis && is_st(ls_sel)});
        chk("exc_badvaddr", exc_badvaddr, exp_bad);
        @(posedge clk);
        #1;
        if (resetn) begin
            if (pp) void'(ot_q.pop_front());
            if (psh) ot_q.push_back(req_q.pop_front());
            if (acc && nbytes(ls_sel) != 0) begin
                if (EXC && mis) begin
                    exp_bad = ls_addr;
                end else begin
                    r.sel = ls_sel; r.wdata = ls_wdata; r.tag = ls_tag;
                    r.addr = (nbytes(ls_sel) > 1) ? ls_addr - (ls_addr % nbytes(ls_sel)) : ls_addr;
                    req_q.push_back(r);
                end
            end
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        set_req(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
        data_addr_ok = 1'b0;
        req_q.delete(); ot_q.delete();
        exp_bad = 32'h0;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst_data_req", {31'h0, data_req}, 32'd0);
        chk("rst_ls_ready", {31'h0, ls_ready}, 32'd1);
        chk("rst_badvaddr", exc_badvaddr, 32'h0);
        tick();
        resetn = 1'b1;
    endtask

    logic [3:0] sel_tab [9];

    initial begin
        sel_tab = '{LB, LBU, LH, LHU, LW, SB, SH, SW, 4'hF};
        #2;
        do_reset();

        // SW word store: single beat, data_ok two cycles after addr_ok, no response.
        set_req(1'b1, SW, 32'h104, 32'h12345678, 5'd1); tick();
        set_req(1'b0, SW, 32'h0, 32'h0, 5'd0); data_addr_ok = 1'b1; tick();
        data_addr_ok = 1'b0; tick(); tick();
        data_data_ok = 1'b1; tick();
        data_data_ok = 1'b0; tick();

        // SB on the top lane, then LB from the same byte with a negative value.
        set_req(1'b1, SB, 32'h103, 32'h000000AB, 5'd2); tick();
        set_req(1'b1, LB, 32'h103, 32'h0, 5'd3); data_addr_ok = 1'b1; tick();
        set_req(1'b0, LB, 32'h0, 32'h0, 5'd0); tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1122_3344; tick();
        data_rdata = 32'h80123456; tick();
        data_data_ok = 1'b0; tick();

        // Back-to-back LW with the address phase stalled three cycles.
        set_req(1'b1, LW, 32'h200, 32'h0, 5'd4); tick();
        set_req(1'b1, LW, 32'h204, 32'h0, 5'd5);
        repeat (3) tick();
        data_addr_ok = 1'b1; tick();
        set_req(1'b0, LW, 32'h0, 32'h0, 5'd0); tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = $urandom; tick();
        data_rdata = $urandom; tick();
        data_data_ok = 1'b0; tick();

        // Three loads against a two-deep FIFO: the third waits for the first data_ok.
        set_req(1'b1, LHU, 32'h302, 32'h0, 5'd6); tick();
        set_req(1'b1, LH, 32'h306, 32'h0, 5'd7); data_addr_ok = 1'b1; tick();
        set_req(1'b1, LBU, 32'h309, 32'h0, 5'd8); tick();
        set_req(1'b0, LB, 32'h0, 32'h0, 5'd0); tick(); tick();
        data_data_ok = 1'b1; data_rdata = 32'hF00D_8001; tick();
        data_addr_ok = 1'b0; data_rdata = 32'h9ABC_DEF0; tick();
        data_rdata = 32'h00FF_0000; tick();
        data_data_ok = 1'b0; tick();

        // Misaligned LH: exception or aligned bus access depending on the build.
        set_req(1'b1, LH, 32'h101, 32'h0, 5'd9); tick();
        set_req(1'b0, LH, 32'h0, 32'h0, 5'd0); data_addr_ok = 1'b1; tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000_8765; tick();
        data_data_ok = 1'b0; tick();

        // Unknown select code: accepted silently.
        set_req(1'b1, 4'hF, 32'h400, 32'h0, 5'd10); tick();
        set_req(1'b0, 4'hF, 32'h0, 32'h0, 5'd0); tick();

        // Reset with two loads outstanding, then a stray data_ok.
        set_req(1'b1, LW, 32'h500, 32'h0, 5'd11); tick();
        set_req(1'b1, LW, 32'h504, 32'h0, 5'd12); data_addr_ok = 1'b1; tick();
        set_req(1'b0, LW, 32'h0, 32'h0, 5'd0); tick();
        data_addr_ok = 1'b0;
        do_reset();
        data_data_ok = 1'b1; data_rdata = $urandom; tick();
        data_data_ok = 1'b0; tick();

        // Random traffic with random bus timing.
        for (int i = 0; i < 400; i++) begin
            set_req(1'($urandom_range(0, 1)), sel_tab[$urandom_range(0, 8)],
                    32'h600 + 32'($urandom_range(0, 15)), $urandom, 5'($urandom));
            data_addr_ok = 1'($urandom_range(0, 1));
            data_data_ok = 1'($urandom_range(0, 1));
            data_rdata   = $urandom;
            tick();
        end
        set_req(1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        repeat (8) tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
